// File: rtl/conv_pkg.sv
// Shared types for the streaming convolution / max-pool engine:
// FSM states, mode encodings and the result-width derivation.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } conv_state_e;

    typedef enum logic {
        MODE_CONV    = 1'b0,
        MODE_MAXPOOL = 1'b1
    } conv_mode_e;

    // Wide enough for taps * (2^dw-1)^2 with no overflow.
    function automatic int calc_rw(input int dw, input int taps);
        return 2 * dw + $clog2(taps);
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Per-tap operand select from the latched image/kernel and the registered
// accumulator (sum of products or running maximum) with synchronous clear.
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int N   = 4,
    parameter int K   = 3,
    parameter int DW  = 8,
    parameter int RW  = 20,
    parameter int RCW = 2,
    parameter int TW  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N*N*DW-1:0]   img,
    input  logic [K*K*DW-1:0]   kern,
    input  conv_mode_e          mode,
    input  logic [RCW-1:0]      win_row,
    input  logic [RCW-1:0]      win_col,
    input  logic [TW-1:0]       tap_i,
    input  logic [TW-1:0]       tap_j,
    input  logic                clear,
    input  logic                en,
    output logic [RW-1:0]       acc_next
);

    logic [RW-1:0]   acc_q;
    logic [RW-1:0]   acc_d;
    logic [DW-1:0]   d_sel;
    logic [DW-1:0]   f_sel;
    logic [2*DW-1:0] prod;
    int              img_idx;
    int              kern_idx;

    always_comb begin
        img_idx  = (int'(win_row) + int'(tap_i)) * N + int'(win_col) + int'(tap_j);
        kern_idx = int'(tap_i) * K + int'(tap_j);
        d_sel    = img[img_idx*DW +: DW];
        f_sel    = kern[kern_idx*DW +: DW];
        prod     = {{DW{1'b0}}, d_sel} * {{DW{1'b0}}, f_sel};
        if (mode == MODE_MAXPOOL) begin
            acc_next = (RW'(d_sel) > acc_q) ? RW'(d_sel) : acc_q;
        end else begin
            acc_next = acc_q + RW'(prod);
        end
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/conv_stream_engine.sv
// Frame engine: latches image/kernel on start, walks every valid window one
// tap per cycle and streams each window result over a valid/ready port.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int N  = 4,
    parameter int K  = 3,
    parameter int DW = 8,
    parameter int RW = conv_pkg::calc_rw(DW, K * K)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            mode,
    input  logic [N*N*DW-1:0]               DATA,
    input  logic [K*K*DW-1:0]               FILTER,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [RW-1:0]                   out_data,
    output logic [$clog2(N-K+1+1)-1+1:0]    out_row,
    output logic [$clog2(N-K+1+1)-1+1:0]    out_col,
    output logic                            done,
    output conv_state_e                     dbg_state
);

    localparam int RCW = $clog2(N-K+1+1) + 1;
    localparam int TW  = $clog2(K) + 1;

    if (N < K) begin : g_bad_size
        $error("conv_stream_engine: N must be >= K");
    end

    conv_state_e         state_q, state_d;
    logic [N*N*DW-1:0]   img_q, img_d;
    logic [K*K*DW-1:0]   kern_q, kern_d;
    conv_mode_e          mode_q, mode_d;
    logic [RCW-1:0]      row_q, row_d, col_q, col_d;
    logic [TW-1:0]       tap_i_q, tap_i_d, tap_j_q, tap_j_d;
    logic [RW-1:0]       out_data_q, out_data_d;
    logic [RCW-1:0]      out_row_q, out_row_d, out_col_q, out_col_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                acc_clear, acc_en;
    logic [RW-1:0]       acc_next;
    logic                last_tap, last_win;

    conv_mac_unit #(
        .N(N), .K(K), .DW(DW), .RW(RW), .RCW(RCW), .TW(TW)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .img      (img_q),
        .kern     (kern_q),
        .mode     (mode_q),
        .win_row  (row_q),
        .win_col  (col_q),
        .tap_i    (tap_i_q),
        .tap_j    (tap_j_q),
        .clear    (acc_clear),
        .en       (acc_en),
        .acc_next (acc_next)
    );

    assign last_tap = (tap_i_q == TW'(K - 1)) && (tap_j_q == TW'(K - 1));
    assign last_win = (row_q == RCW'(N - K)) && (col_q == RCW'(N - K));

    // Output handshake: out_valid rises with a result and stays high, with
    // out_data/out_row/out_col frozen, until an edge where out_ready is high.
    always_comb begin
        state_d     = state_q;
        img_d       = img_q;
        kern_d      = kern_q;
        mode_d      = mode_q;
        row_d       = row_q;
        col_d       = col_q;
        tap_i_d     = tap_i_q;
        tap_j_d     = tap_j_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        acc_clear   = 1'b0;
        acc_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    img_d     = DATA;
                    kern_d    = FILTER;
                    mode_d    = conv_mode_e'(mode);
                    row_d     = '0;
                    col_d     = '0;
                    tap_i_d   = '0;
                    tap_j_d   = '0;
                    acc_clear = 1'b1;
                    state_d   = MAC;
                end
            end
            MAC: begin
                acc_en = 1'b1;
                if (last_tap) begin
                    out_data_d  = acc_next;
                    out_row_d   = row_q;
                    out_col_d   = col_q;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else if (tap_j_q == TW'(K - 1)) begin
                    tap_j_d = '0;
                    tap_i_d = tap_i_q + TW'(1);
                end else begin
                    tap_j_d = tap_j_q + TW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_win) begin
                        state_d = DONE;
                    end else begin
                        if (col_q == RCW'(N - K)) begin
                            col_d = '0;
                            row_d = row_q + RCW'(1);
                        end else begin
                            col_d = col_q + RCW'(1);
                        end
                        tap_i_d   = '0;
                        tap_j_d   = '0;
                        acc_clear = 1'b1;
                        state_d   = MAC;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == MAC) || (state_d == OUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            img_q       <= '0;
            kern_q      <= '0;
            mode_q      <= MODE_CONV;
            row_q       <= '0;
            col_q       <= '0;
            tap_i_q     <= '0;
            tap_j_q     <= '0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            img_q       <= img_d;
            kern_q      <= kern_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tap_i_q     <= tap_i_d;
            tap_j_q     <= tap_j_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine: vector table of full frames plus
// hand-written stall, restart-ignore and mid-frame reset sequences.
module tb_conv_stream_engine;
    import conv_pkg::*;

    localparam int N   = 4;
    localparam int K   = 3;
    localparam int DW  = 8;
    localparam int RW  = 2 * DW + $clog2(K * K);
    localparam int RCW = $clog2(N - K + 1 + 1) + 1;
    localparam int NWIN = (N - K + 1) * (N - K + 1);
    localparam int BASE_DONE = NWIN * (K * K + 1) + 1;

    typedef struct {
        logic [N*N*DW-1:0] data;
        logic [K*K*DW-1:0] filt;
        logic              mode;
        logic [RW-1:0]     exp_res [NWIN];
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [N*N*DW-1:0] data_in = '0;
    logic [K*K*DW-1:0] filt_in = '0;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [RW-1:0]     out_data;
    logic [RCW-1:0]    out_row;
    logic [RCW-1:0]    out_col;
    logic              done;
    conv_state_e       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs [5];

    always #5 clk = ~clk;

    conv_stream_engine #(.N(N), .K(K), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .DATA      (data_in),
        .FILTER    (filt_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .done      (done),
        .dbg_state (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [N*N*DW-1:0] ramp_img();
        logic [N*N*DW-1:0] v;
        v = '0;
        for (int k = 0; k < N * N; k++) v[k*DW +: DW] = DW'(k);
        return v;
    endfunction

    function automatic vec_t mk_vec(input logic [N*N*DW-1:0] d, input logic [K*K*DW-1:0] f,
                                    input logic m, input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.data = d;
        v.filt = f;
        v.mode = m;
        v.exp_res[0] = RW'(e0);
        v.exp_res[1] = RW'(e1);
        v.exp_res[2] = RW'(e2);
        v.exp_res[3] = RW'(e3);
        return v;
    endfunction

    // Runs one frame; samples on the falling edge, cyc = rising edges since start edge.
    task automatic run_frame(input int vi, input int stall_len, input int mid_start_cyc,
                             input bit start_in_done);
        int cyc;
        int ridx;
        int stall_cnt;
        int first_valid;
        int done_cyc;
        int exp_done;
        exp_done    = BASE_DONE + stall_len;
        ridx        = 0;
        stall_cnt   = 0;
        first_valid = -1;
        done_cyc    = -1;
        @(negedge clk);
        data_in   = vecs[vi].data;
        filt_in   = vecs[vi].filt;
        mode      = vecs[vi].mode;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        data_in = '1;
        filt_in = '0;
        mode    = ~vecs[vi].mode;
        for (cyc = 0; cyc < 200; cyc++) begin
            start = (cyc == mid_start_cyc) || (start_in_done && cyc == exp_done - 1);
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid) begin
                if (ridx == 1 && stall_cnt < stall_len) begin
                    chk("stall_data", out_data, vecs[vi].exp_res[1]);
                    chk("stall_col", out_col, 1);
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                    if (ridx < NWIN) begin
                        chk($sformatf("v%0d_res%0d_data", vi, ridx), out_data, vecs[vi].exp_res[ridx]);
                        chk($sformatf("v%0d_res%0d_row", vi, ridx), out_row, ridx / 2);
                        chk($sformatf("v%0d_res%0d_col", vi, ridx), out_col, ridx % 2);
                    end
                    ridx++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done && done_cyc < 0) begin
                done_cyc = cyc;
                chk("busy_with_done", busy, 0);
            end
            if (cyc == exp_done + 1) begin
                chk("done_single_pulse", done, 0);
                chk("busy_after_done", busy, 0);
                chk("idle_after_done", dbg_state, IDLE);
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("v%0d_result_count", vi), ridx, NWIN);
        chk($sformatf("v%0d_first_valid_cyc", vi), first_valid, K * K);
        chk($sformatf("v%0d_done_cyc", vi), done_cyc, exp_done);
    endtask

    initial begin
        logic [N*N*DW-1:0] centre_filt_tmp;
        logic [K*K*DW-1:0] centre_filt;
        bit saw_done;
        centre_filt = '0;
        centre_filt[4*DW +: DW] = DW'(1);
        centre_filt_tmp = '0;

        vecs[0] = mk_vec({(N*N){8'd1}}, {(K*K){8'd1}}, 1'b0, 9, 9, 9, 9);
        vecs[1] = mk_vec(ramp_img(), centre_filt, 1'b0, 5, 6, 9, 10);
        vecs[2] = mk_vec(ramp_img(), {(K*K){8'h5a}}, 1'b1, 10, 11, 14, 15);
        vecs[3] = mk_vec({(N*N){8'd255}}, {(K*K){8'd255}}, 1'b0, 585225, 585225, 585225, 585225);
        vecs[4] = mk_vec(ramp_img(), {(K*K){8'd1}}, 1'b0, 45, 54, 81, 90);

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        chk("rst_state", dbg_state, IDLE);
        rst = 1'b1;

        for (int v = 0; v < 5; v++) run_frame(v, 0, -1, 1'b0);

        // Consumer back-pressure on the second result.
        run_frame(1, 5, -1, 1'b0);
        // start mid-MAC with different inputs must be ignored.
        run_frame(1, 0, 3, 1'b0);
        // start in the DONE cycle must not restart the engine.
        run_frame(0, 0, -1, 1'b1);

        // Reset during the third window.
        @(negedge clk);
        data_in = vecs[1].data;
        filt_in = vecs[1].filt;
        mode    = vecs[1].mode;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (22) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_row", out_row, 0);
        chk("mid_rst_col", out_col, 0);
        chk("mid_rst_state", dbg_state, IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("no_done_after_rst", saw_done, 0);

        run_frame(4, 0, -1, 1'b0);
        run_frame(2, 0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
